// File: rtl/cvp14_pkg.sv
// Shared CVP14 front-end definitions: datapath widths, opcode values and
// the fetch sequencer state encoding.
package cvp14_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 5;
  localparam int FT_W    = 4;
  localparam int OFF_W   = 12;

  localparam logic [FT_W-1:0] OP_VADD = 4'h0;
  localparam logic [FT_W-1:0] OP_VSUB = 4'h1;
  localparam logic [FT_W-1:0] OP_VMUL = 4'h2;
  localparam logic [FT_W-1:0] OP_VLD  = 4'h3;
  localparam logic [FT_W-1:0] OP_VST  = 4'h4;
  localparam logic [FT_W-1:0] OP_J    = 4'h8;
  localparam logic [FT_W-1:0] OP_NOP  = 4'hF;

  // Encodes a NOP, so the decoder sees a harmless word until the first fetch lands.
  localparam logic [INSTR_W-1:0] INSTR_RESET = 16'hF000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_STALL = 2'd3
  } fetch_state_e;

  function automatic logic [PC_W-1:0] jumpTarget(input logic [PC_W-1:0]  pcIn,
                                                 input logic [OFF_W-1:0] offset);
    return pcIn + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: REQ -> WAIT -> ISSUE, then STALL for multi-cycle ops.
// Define FETCH_PERF_CNT_EN to add the issue_count / stall_count counters.
module instr_fetch
  import cvp14_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic [FT_W-1:0]    functype,
  input  logic [CNT_W-1:0]   cycleCount,
  input  logic [OFF_W-1:0]   jumpOffset,
  input  logic               hold,
  output logic               busy,
  output logic [CNT_W-1:0]   step_idx,
  output logic [PC_W-1:0]    pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        issue_count,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stepIdx_q, stepIdx_d;
  logic               instrValid_q, instrValid_d;
  logic               busy_q, busy_d;
  logic               lastStep;

  // The read strobe follows hold combinationally so a fetch starts the cycle hold drops.
  assign imem_rd     = (state_q == ST_REQ) && !hold && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instrValid_q;
  assign busy        = busy_q;
  assign step_idx    = stepIdx_q;
  assign lastStep    = (stepIdx_q == cnt_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    instrValid_d = 1'b0;
    busy_d       = 1'b0;
    stepIdx_d    = '0;
    case (state_q)
      ST_REQ: begin
        if (!hold) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        instr_d      = imem_rdata;
        instrValid_d = 1'b1;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_REQ;
        if (functype == OP_J) begin
          pc_d = jumpTarget(pc_q, jumpOffset);
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (cycleCount != '0) begin
            cnt_d   = cycleCount;
            busy_d  = 1'b1;
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (lastStep) begin
          state_d = ST_REQ;
        end else begin
          busy_d    = 1'b1;
          stepIdx_d = stepIdx_q + CNT_W'(1);
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= '0;
      instr_q      <= INSTR_RESET;
      cnt_q        <= '0;
      stepIdx_q    <= '0;
      instrValid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      stepIdx_q    <= stepIdx_d;
      instrValid_q <= instrValid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] issueCount_q;
  logic [31:0] stallCount_q;

  // Counters advance off the registered issue/stall flags and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      issueCount_q <= '0;
      stallCount_q <= '0;
    end else begin
      if (instrValid_q) issueCount_q <= issueCount_q + 32'd1;
      if (busy_q)       stallCount_q <= stallCount_q + 32'd1;
    end
  end

  assign issue_count = issueCount_q;
  assign stall_count = stallCount_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model predicts every fetch,
// issue and stall cycle; a negedge monitor compares the DUT against it.
module tb_instr_fetch;
  import cvp14_pkg::*;

  localparam int MAXC = 1024;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] word;
  } event_t;

  logic               clk;
  logic               rst;
  logic               hold;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [FT_W-1:0]    functype;
  logic [CNT_W-1:0]   cycleCount;
  logic [OFF_W-1:0]   jumpOffset;
  logic               busy;
  logic [CNT_W-1:0]   step_idx;
  logic [PC_W-1:0]    pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        issue_count;
  logic [31:0]        stall_count;
  int                 expIssBefore [0:MAXC-1];
  int                 expStallBefore [0:MAXC-1];
  logic               expIv [0:MAXC-1];
`endif

  logic [INSTR_W-1:0] mem [0:65535];
  logic [CNT_W-1:0]   ccOf [0:15];
  logic               holdAt [0:MAXC-1];
  logic               expBusy [0:MAXC-1];
  int                 expStep [0:MAXC-1];
  int                 expPc [0:MAXC-1];
  event_t             fetchQ[$];
  event_t             issueQ[$];
  int                 segLen;
  int                 cyc;
  logic               inSeg;
  logic               inRst;
  int                 checkCount;
  int                 passCount;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .functype   (functype),
    .cycleCount (cycleCount),
    .jumpOffset (jumpOffset),
    .hold       (hold),
    .busy       (busy),
    .step_idx   (step_idx),
    .pc         (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .issue_count(issue_count),
    .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decoder stand-in: opcode in the top nibble, offset in the low 12 bits,
  // element count looked up per opcode from a table the stimulus controls.
  assign functype   = instr[15:12];
  assign jumpOffset = instr[11:0];
  assign cycleCount = ccOf[instr[15:12]];

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
  endtask

  // Walks the program instruction by instruction and records what each cycle should show.
  task automatic buildModel();
    int t, p, n, off;
    logic [15:0] w;
    event_t e;
    for (int c = 0; c < MAXC; c++) begin
      expBusy[c] = 1'b0;
      expStep[c] = 0;
      expPc[c]   = 0;
`ifdef FETCH_PERF_CNT_EN
      expIv[c]   = 1'b0;
`endif
    end
    fetchQ.delete();
    issueQ.delete();
    t = 0;
    p = 0;
    while (t <= segLen) begin
      if (holdAt[t]) begin
        expPc[t] = p;
        t++;
        continue;
      end
      w = mem[p];
      for (int k = 0; k < 3; k++) expPc[t+k] = p;
      e.addr = p;
      e.word = w;
      if (t < segLen) begin
        e.cyc = t;
        fetchQ.push_back(e);
      end
      if (t + 2 < segLen) begin
        e.cyc = t + 2;
        issueQ.push_back(e);
      end
`ifdef FETCH_PERF_CNT_EN
      expIv[t+2] = 1'b1;
`endif
      if (w[15:12] == OP_J) begin
        off = int'(w[11:0]);
        if (off >= 2048) off -= 4096;
        p = (p + off + 65536) % 65536;
        n = 0;
      end else begin
        p = (p + 1) % 65536;
        n = int'(ccOf[w[15:12]]);
      end
      for (int k = 0; k < n; k++) begin
        expBusy[t+3+k] = 1'b1;
        expStep[t+3+k] = k;
        expPc[t+3+k]   = p;
      end
      t = t + 3 + n;
    end
`ifdef FETCH_PERF_CNT_EN
    begin
      int ri, rs;
      ri = 0;
      rs = 0;
      for (int c = 0; c <= segLen; c++) begin
        expIssBefore[c]   = ri;
        expStallBefore[c] = rs;
        ri += int'(expIv[c]);
        rs += int'(expBusy[c]);
      end
    end
`endif
  endtask

  task automatic monitorCycle();
    bit fetchNow, issueNow;
    event_t e;
    fetchNow = (fetchQ.size() > 0) && (fetchQ[0].cyc == cyc);
    checkOutput("imemRd", 32'(imem_rd), 32'(fetchNow));
    if (fetchNow) begin
      e = fetchQ.pop_front();
      if (imem_rd) checkOutput("imemAddr", 32'(imem_addr), 32'(e.addr));
    end
    issueNow = (issueQ.size() > 0) && (issueQ[0].cyc == cyc);
    checkOutput("instrValid", 32'(instr_valid), 32'(issueNow));
    if (issueNow) begin
      e = issueQ.pop_front();
      if (instr_valid) begin
        checkOutput("instr", 32'(instr), 32'(e.word));
        checkOutput("issuePc", 32'(pc), 32'(e.addr));
      end
    end
    checkOutput("busy", 32'(busy), 32'(expBusy[cyc]));
    checkOutput("stepIdx", 32'(step_idx), 32'(expStep[cyc]));
    checkOutput("pc", 32'(pc), 32'(expPc[cyc]));
    if (cyc == 0) checkOutput("instrAfterReset", 32'(instr), 32'(INSTR_RESET));
`ifdef FETCH_PERF_CNT_EN
    checkOutput("issueCount", issue_count, 32'(expIssBefore[cyc]));
    checkOutput("stallCount", stall_count, 32'(expStallBefore[cyc]));
`endif
  endtask

  // Monitor: checks at the falling edge, clear of the rising-edge updates.
  always @(negedge clk) begin
    if (inRst) begin
      checkOutput("rdInReset", 32'(imem_rd), 32'd0);
      checkOutput("busyAtReset", 32'(busy), 32'(expBusy[segLen]));
      checkOutput("stepAtReset", 32'(step_idx), 32'(expStep[segLen]));
    end else if (inSeg) begin
      monitorCycle();
    end
  end

  task automatic clearProgram();
    for (int a = 0; a < 65536; a++) mem[a] = INSTR_RESET;
    for (int i = 0; i < 16; i++) ccOf[i] = '0;
  endtask

  task automatic randomProgram();
    int r;
    logic [FT_W-1:0] vecOps [5];
    vecOps = '{OP_VADD, OP_VSUB, OP_VMUL, OP_VLD, OP_VST};
    for (int a = 0; a < 65536; a++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      mem[a] = {OP_J, 12'($urandom)};
      else if (r < 22) mem[a] = {OP_NOP, 12'($urandom)};
      else             mem[a] = 16'($urandom);
    end
    for (int i = 0; i < 16; i++) ccOf[i] = 5'($urandom_range(0, 4));
    foreach (vecOps[j])
      ccOf[vecOps[j]] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(1, 6));
    ccOf[OP_NOP] = '0;
    ccOf[OP_J]   = 5'($urandom);
    for (int c = 0; c < MAXC; c++) holdAt[c] = ($urandom_range(0, 4) == 0);
  endtask

  // One segment: a reset cycle (aborting whatever ran before), program setup, then len cycles.
  task automatic applyStimulus(input int kind, input int len);
    inSeg = 1'b0;
    inRst = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    inRst = 1'b0;
    checkOutput("pendingFetches", 32'(fetchQ.size()), 32'd0);
    checkOutput("pendingIssues", 32'(issueQ.size()), 32'd0);
    segLen = len;
    for (int c = 0; c < MAXC; c++) holdAt[c] = 1'b0;
    clearProgram();
    case (kind)
      1: begin
        mem[4] = 16'h0000;
        ccOf[OP_VADD] = 5'd15;
      end
      2: begin
        mem[10] = 16'h8FFE;
        ccOf[OP_J] = 5'd5;
      end
      3: mem[3] = 16'h8000;
      4: for (int c = 0; c < 5; c++) holdAt[c] = 1'b1;
      5: begin
        mem[0] = {OP_VLD, 12'h000};
        ccOf[OP_VLD] = 5'd16;
      end
      6: begin
        mem[0] = 16'h8FFF;
        mem[1] = {OP_VST, 12'h000};
        ccOf[OP_VST] = 5'd2;
      end
      7: randomProgram();
      default: ;
    endcase
    buildModel();
    cyc   = 0;
    hold  = holdAt[0];
    inSeg = 1'b1;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      hold = holdAt[cyc];
      if (cyc == segLen) break;
    end
  endtask

  initial begin
    rst        = 1'b1;
    hold       = 1'b0;
    inSeg      = 1'b0;
    inRst      = 1'b0;
    cyc        = 0;
    segLen     = 0;
    checkCount = 0;
    passCount  = 0;
    for (int c = 0; c < MAXC; c++) begin
      expBusy[c] = 1'b0;
      expStep[c] = 0;
      expPc[c]   = 0;
      holdAt[c]  = 1'b0;
    end
    clearProgram();
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 12);
    applyStimulus(1, 40);
    applyStimulus(2, 50);
    applyStimulus(3, 30);
    applyStimulus(4, 20);
    applyStimulus(5, 10);
    applyStimulus(6, 20);
    applyStimulus(0, 8);
    for (int s = 0; s < 8; s++) applyStimulus(7, $urandom_range(150, 400));
    inSeg = 1'b0;
    checkOutput("pendingFetches", 32'(fetchQ.size()), 32'd0);
    checkOutput("pendingIssues", 32'(issueQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
